// File: rtl/cache_sa.sv
// N-way set-associative write-back cache with round-robin victim choice.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module cache_sa #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 1024,
    parameter int WAYS       = 2,
    localparam int LW        = 32 * LINE_WORDS
) (
    input  logic              clk,
    input  logic              r,
    input  logic              cpu2cache_valid,
    input  logic              cpu2cache_rw,
    input  logic [ADDR_W-1:0] cpu2cache_addr,
    input  logic [31:0]       cpu2cache_data,
    output logic [31:0]       cache2cpu_data,
    output logic              cache2cpu_ready,
    output logic              cache2mem_valid,
    output logic              cache2mem_rw,
    output logic [ADDR_W-1:0] cache2mem_addr,
    output logic [LW-1:0]     cache2mem_data,
    input  logic [LW-1:0]     mem2cache_data,
    input  logic              mem2cache_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam int IW  = $clog2(SETS);
    localparam int TW  = ADDR_W - OFF - IW;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state_q, state_d;
    logic   rd_q, rd_d;

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] dirty_q;
    logic [SETS-1:0][WW-1:0]   ptr_q;

    logic [TW-1:0] tag_mem  [SETS][WAYS];
    logic [LW-1:0] data_mem [SETS][WAYS];
    logic [TW-1:0] st_tag   [WAYS];
    logic [LW-1:0] st_data  [WAYS];

    logic          req_rw;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [BW-1:0] req_word;
    logic [31:0]   req_data;
    logic          first_q;
    logic [WW-1:0] vic_q;

    logic            accept;
    logic            cmp_go;
    logic            mem_fire;
    logic [WAYS-1:0] hit_vec;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   vic_way;
    logic            set_full;
    logic [WW-1:0]   ptr_nxt;
    logic [31:0]     rd_word;
    logic [LW-1:0]   wr_line;
    logic            unused_bits;

    assign unused_bits = ^cpu2cache_addr[1:0];
    assign accept   = cpu2cache_valid && !cache2cpu_ready;
    assign cmp_go   = (state_q == COMPARE) && !rd_q;
    assign mem_fire = cache2mem_valid && mem2cache_ready;

    // rd_q marks the array-read cycle that precedes the tag compare
    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        vic_way  = ptr_q[req_idx];
        set_full = &valid_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[req_idx][w] &&
                         (st_tag[w] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WW'(w);
            if (!valid_q[req_idx][w]) vic_way = WW'(w);
        end
        hit     = |hit_vec;
        rd_word = st_data[hit_way][req_word*32 +: 32];
        wr_line = st_data[hit_way];
        wr_line[req_word*32 +: 32] = req_data;
        if (ptr_q[req_idx] == WW'(WAYS - 1))
            ptr_nxt = '0;
        else
            ptr_nxt = ptr_q[req_idx] + 1'b1;
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COMPARE;
                    rd_d    = 1'b1;
                end
            end
            COMPARE: begin
                if (rd_q)
                    rd_d = 1'b0;
                else if (hit)
                    state_d = IDLE;
                else if (valid_q[req_idx][vic_way] &&
                         dirty_q[req_idx][vic_way])
                    state_d = WRITEBACK;
                else
                    state_d = ALLOCATE;
            end
            WRITEBACK: begin
                if (mem_fire) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (mem_fire) begin
                    state_d = COMPARE;
                    rd_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            valid_q         <= '0;
            dirty_q         <= '0;
            ptr_q           <= '0;
            req_rw          <= 1'b0;
            req_tag         <= '0;
            req_idx         <= '0;
            req_word        <= '0;
            req_data        <= '0;
            first_q         <= 1'b0;
            vic_q           <= '0;
            cache2cpu_data  <= '0;
            cache2cpu_ready <= 1'b0;
            cache2mem_valid <= 1'b0;
            cache2mem_rw    <= 1'b0;
            cache2mem_addr  <= '0;
            cache2mem_data  <= '0;
        end else begin
            cache2cpu_ready <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_rw   <= cpu2cache_rw;
                        req_tag  <= cpu2cache_addr[ADDR_W-1 -: TW];
                        req_idx  <= cpu2cache_addr[OFF +: IW];
                        req_word <= cpu2cache_addr[OFF-1:2];
                        req_data <= cpu2cache_data;
                        first_q  <= 1'b1;
                    end
                end
                COMPARE: begin
                    if (!rd_q) begin
                        first_q <= 1'b0;
                        if (hit) begin
                            cache2cpu_ready <= 1'b1;
                            if (!req_rw)
                                cache2cpu_data <= rd_word;
                            else
                                dirty_q[req_idx][hit_way] <= 1'b1;
                        end else begin
                            vic_q <= vic_way;
                            if (set_full)
                                ptr_q[req_idx] <= ptr_nxt;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!cache2mem_valid) begin
                        cache2mem_valid <= 1'b1;
                        cache2mem_rw    <= 1'b1;
                        cache2mem_addr  <= {st_tag[vic_q], req_idx,
                                            {OFF{1'b0}}};
                        cache2mem_data  <= st_data[vic_q];
                    end else if (mem2cache_ready) begin
                        cache2mem_valid <= 1'b0;
                        cache2mem_rw    <= 1'b0;
                        cache2mem_addr  <= '0;
                        cache2mem_data  <= '0;
                    end
                end
                ALLOCATE: begin
                    if (!cache2mem_valid) begin
                        cache2mem_valid <= 1'b1;
                        cache2mem_rw    <= 1'b0;
                        cache2mem_addr  <= {req_tag, req_idx,
                                            {OFF{1'b0}}};
                        cache2mem_data  <= '0;
                    end else if (mem2cache_ready) begin
                        cache2mem_valid <= 1'b0;
                        cache2mem_addr  <= '0;
                        valid_q[req_idx][vic_q] <= 1'b1;
                        dirty_q[req_idx][vic_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // tag/data storage is not reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && rd_q) begin
            for (int w = 0; w < WAYS; w++) begin
                st_tag[w]  <= tag_mem[req_idx][w];
                st_data[w] <= data_mem[req_idx][w];
            end
        end
        if (cmp_go && hit && req_rw)
            data_mem[req_idx][hit_way] <= wr_line;
        if (state_q == ALLOCATE && mem_fire) begin
            data_mem[req_idx][vic_q] <= mem2cache_data;
            tag_mem[req_idx][vic_q]  <= req_tag;
            st_data[vic_q]           <= mem2cache_data;
            st_tag[vic_q]            <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (cmp_go && first_q) begin
            if (hit && hit_q != '1)
                hit_q <= hit_q + 1'b1;
            if (!hit && miss_q != '1)
                miss_q <= miss_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa with a small line-memory responder.
// Counter expectations follow CACHE_STATS_EN.
module tb_cache_sa;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         r;
    logic         cpu2cache_valid;
    logic         cpu2cache_rw;
    logic [31:0]  cpu2cache_addr;
    logic [31:0]  cpu2cache_data;
    logic [31:0]  cache2cpu_data;
    logic         cache2cpu_ready;
    logic         cache2mem_valid;
    logic         cache2mem_rw;
    logic [31:0]  cache2mem_addr;
    logic [127:0] cache2mem_data;
    logic [127:0] mem2cache_data;
    logic         mem2cache_ready;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    always #5 clk = ~clk;

    cache_sa dut (
        .clk             (clk),
        .r               (r),
        .cpu2cache_valid (cpu2cache_valid),
        .cpu2cache_rw    (cpu2cache_rw),
        .cpu2cache_addr  (cpu2cache_addr),
        .cpu2cache_data  (cpu2cache_data),
        .cache2cpu_data  (cache2cpu_data),
        .cache2cpu_ready (cache2cpu_ready),
        .cache2mem_valid (cache2mem_valid),
        .cache2mem_rw    (cache2mem_rw),
        .cache2mem_addr  (cache2mem_addr),
        .cache2mem_data  (cache2mem_data),
        .mem2cache_data  (mem2cache_data),
        .mem2cache_ready (mem2cache_ready),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [127:0] fill_line;
    bit           mem_en;
    int           txn_n;
    logic         txn_rw   [16];
    logic [31:0]  txn_addr [16];
    logic [127:0] txn_data [16];

    // answers each memory request on its third visible cycle
    initial begin
        int wcnt;
        wcnt = 0;
        txn_n = 0;
        mem2cache_ready = 1'b0;
        mem2cache_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem2cache_ready = 1'b0;
            if (mem_en && cache2mem_valid) begin
                wcnt++;
                if (wcnt == 3) begin
                    if (txn_n < 16) begin
                        txn_rw[txn_n]   = cache2mem_rw;
                        txn_addr[txn_n] = cache2mem_addr;
                        txn_data[txn_n] = cache2mem_data;
                    end
                    txn_n++;
                    mem2cache_data  = cache2mem_rw ? '0 : fill_line;
                    mem2cache_ready = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic cpu_req(input logic rw,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           output logic [31:0] q,
                           output int lat);
        bit ok;
        ok  = 1'b0;
        lat = -1;
        q   = '0;
        cpu2cache_valid = 1'b1;
        cpu2cache_rw    = rw;
        cpu2cache_addr  = a;
        cpu2cache_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (cache2cpu_ready) begin
                ok  = 1'b1;
                lat = i;
                q   = cache2cpu_data;
            end
        end
        cpu2cache_valid = 1'b0;
        if (!ok) chk("req_timeout", 128'(ok), 128'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q;
    int          lat;
    int          t0;
    bit          seen;

    initial begin
        r = 1'b0;
        cpu2cache_valid = 1'b0;
        cpu2cache_rw = 1'b0;
        cpu2cache_addr = '0;
        cpu2cache_data = '0;
        mem_en = 1'b1;
        fill_line = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(cache2cpu_ready), 128'd0);
        chk("rst_mvalid", 128'(cache2mem_valid), 128'd0);
        chk("rst_maddr", 128'(cache2mem_addr), 128'd0);
        chk("rst_hits", 128'(hit_count), 128'd0);
        chk("rst_miss", 128'(miss_count), 128'd0);
        r = 1'b1;
        @(posedge clk);
        #1;

        // cold read miss
        fill_line = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
        cpu_req(1'b0, 32'h0000_2014, '0, q, lat);
        chk("s1_data", 128'(q), 128'hDDDD0001);
        chk("s1_ntxn", 128'(txn_n), 128'd1);
        chk("s1_rw", 128'(txn_rw[0]), 128'd0);
        chk("s1_addr", 128'(txn_addr[0]), 128'h2010);
        chk("s1_wdata", txn_data[0], 128'd0);

        // read hit, exact latency
        seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (cache2mem_valid) seen = 1'b1;
                end
            end
        join_none
        cpu_req(1'b0, 32'h0000_2018, '0, q, lat);
        chk("s2_data", 128'(q), 128'hDDDD0002);
        chk("s2_lat", 128'(lat), 128'd2);
        chk("s2_nomem", 128'(seen), 128'd0);

        // write hit then read back
        cpu_req(1'b1, 32'h0000_2010, 32'hCAFEF00D, q, lat);
        chk("s3_wlat", 128'(lat), 128'd2);
        cpu_req(1'b0, 32'h0000_2010, '0, q, lat);
        chk("s3_data", 128'(q), 128'hCAFEF00D);
        chk("s3_ntxn", 128'(txn_n), 128'd1);

        // fill way1, then evict dirty way0
        fill_line = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
        cpu_req(1'b0, 32'h0010_2010, '0, q, lat);
        chk("s4a_data", 128'(q), 128'hAAAA0000);
        chk("s4a_ntxn", 128'(txn_n), 128'd2);
        chk("s4a_rw", 128'(txn_rw[1]), 128'd0);
        chk("s4a_addr", 128'(txn_addr[1]), 128'h0010_2010);
        fill_line = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
        cpu_req(1'b0, 32'h0020_2010, '0, q, lat);
        chk("s4b_data", 128'(q), 128'hBBBB0000);
        chk("s4b_ntxn", 128'(txn_n), 128'd4);
        chk("s4b_wbrw", 128'(txn_rw[2]), 128'd1);
        chk("s4b_wbaddr", 128'(txn_addr[2]), 128'h2010);
        chk("s4b_wbline", txn_data[2],
            128'hDDDD0003_DDDD0002_DDDD0001_CAFEF00D);
        chk("s4b_fillrw", 128'(txn_rw[3]), 128'd0);
        chk("s4b_filladdr", 128'(txn_addr[3]), 128'h0020_2010);
        chk("s4_hits", 128'(hit_count), STATS ? 128'd3 : 128'd0);
        chk("s4_miss", 128'(miss_count), STATS ? 128'd3 : 128'd0);

        // reset while a fill is outstanding
        mem_en = 1'b0;
        cpu2cache_valid = 1'b1;
        cpu2cache_rw = 1'b0;
        cpu2cache_addr = 32'h0030_2010;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (cache2mem_valid) seen = 1'b1;
        end
        chk("s5_mvalid", 128'(seen), 128'd1);
        chk("s5_alloc", 128'(cache2mem_rw), 128'd0);
        #2;
        r = 1'b0;
        cpu2cache_valid = 1'b0;
        #1;
        chk("s5_rvalid", 128'(cache2mem_valid), 128'd0);
        chk("s5_raddr", 128'(cache2mem_addr), 128'd0);
        chk("s5_rready", 128'(cache2cpu_ready), 128'd0);
        chk("s5_rdata", 128'(cache2cpu_data), 128'd0);
        chk("s5_rhits", 128'(hit_count), 128'd0);
        chk("s5_rmiss", 128'(miss_count), 128'd0);
        @(posedge clk);
        #1;
        r = 1'b1;
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        t0 = txn_n;
        fill_line = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
        cpu_req(1'b0, 32'h0000_2010, '0, q, lat);
        chk("s5_data", 128'(q), 128'hEEEE0000);
        chk("s5_ntxn", 128'(txn_n - t0), 128'd1);
        chk("s5_rw", 128'(txn_rw[t0]), 128'd0);
        chk("s5_addr", 128'(txn_addr[t0]), 128'h2010);
        chk("s5_hits", 128'(hit_count), 128'd0);
        chk("s5_miss", 128'(miss_count), STATS ? 128'd1 : 128'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
